// File: rtl/note_player_if.sv
// note_player_if: note/octave request and buzzer status bundle between controller and note_player.
//   note_in    4  note code from controller (1..7 = C..B, others rest)
//   octave_in  2  octave select from controller
//   mute       1  force silence
//   buzzer     1  square-wave output to the buzzer pad
//   playing    1  high while a note is sounding
//   cur_note   4  latched note being sounded, 0 otherwise
//   cur_octave 2  latched octave being sounded, 0 otherwise
interface note_player_if;
    logic [3:0] note_in;
    logic [1:0] octave_in;
    logic       mute;
    logic       buzzer;
    logic       playing;
    logic [3:0] cur_note;
    logic [1:0] cur_octave;
    modport master (output note_in, octave_in, mute, input buzzer, playing, cur_note, cur_octave);
    modport slave  (input note_in, octave_in, mute, output buzzer, playing, cur_note, cur_octave);
endinterface

// File: rtl/note_player.sv
// note_player: square-wave buzzer driver for note/octave codes, switching notes only at half-period boundaries.
//   clk    1  system clock
//   reset  1  synchronous, active-low
//   bus       note_player_if.slave (note_in, octave_in, mute in; buzzer, playing, cur_note, cur_octave out)
module note_player #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int GAP_CYCLES = 100_000
) (
    input logic           clk,
    input logic           reset,
    note_player_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    // Half-periods at the middle octave for C4..B4 (262..494 Hz)
    localparam logic [19:0] HALF_TAB [8] = '{20'd0, 20'(CLK_HZ/524), 20'(CLK_HZ/588), 20'(CLK_HZ/660),
                                             20'(CLK_HZ/698), 20'(CLK_HZ/784), 20'(CLK_HZ/880), 20'(CLK_HZ/988)};
    state_t      r_state;
    logic [19:0] r_cnt;
    logic [19:0] r_half;
    logic [GW-1:0] r_gcnt;
    logic [3:0]  r_note;
    logic [1:0]  r_oct;
    logic        r_buz;
    logic        r_play;
    logic        w_valid;
    logic        w_same;
    logic        w_bound;
    logic [19:0] w_base;
    logic [19:0] w_half;
    always_comb begin
        w_valid = bus.note_in != 4'd0 && !bus.note_in[3];
        w_same  = bus.note_in == r_note && bus.octave_in == r_oct;
        w_bound = r_cnt == r_half - 20'd1;
        w_base  = HALF_TAB[bus.note_in[2:0]];
        w_half  = bus.octave_in == 2'b00 ? {w_base[18:0], 1'b0} :
                  bus.octave_in == 2'b10 ? {1'b0, w_base[19:1]} : w_base;
    end
    always_ff @(posedge clk) begin
        if (!reset || bus.mute) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_half  <= '0;
            r_gcnt  <= '0;
            r_note  <= '0;
            r_oct   <= '0;
            r_buz   <= 1'b0;
            r_play  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        r_state <= S_PLAY;
                        r_note  <= bus.note_in;
                        r_oct   <= bus.octave_in;
                        r_half  <= w_half;
                        r_cnt   <= '0;
                        r_buz   <= 1'b1;
                        r_play  <= 1'b1;
                    end
                end
                S_PLAY: begin
                    if (!w_bound) begin
                        r_cnt <= r_cnt + 20'd1;
                    end else begin
                        r_cnt <= '0;
                        if (w_valid && w_same) begin
                            r_buz <= ~r_buz;
                        end else if (!w_valid) begin
                            r_state <= S_IDLE;
                            r_buz   <= 1'b0;
                            r_play  <= 1'b0;
                            r_note  <= '0;
                            r_oct   <= '0;
                        end else if (GAP_CYCLES == 0) begin
                            // Continuous wave: new pitch starts on the toggled level
                            r_note <= bus.note_in;
                            r_oct  <= bus.octave_in;
                            r_half <= w_half;
                            r_buz  <= ~r_buz;
                        end else begin
                            r_state <= S_GAP;
                            r_gcnt  <= '0;
                            r_buz   <= 1'b0;
                            r_play  <= 1'b0;
                            r_note  <= '0;
                            r_oct   <= '0;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gcnt != GW'(GAP_CYCLES - 1)) begin
                        r_gcnt <= r_gcnt + 1'b1;
                    end else if (w_valid) begin
                        r_state <= S_PLAY;
                        r_note  <= bus.note_in;
                        r_oct   <= bus.octave_in;
                        r_half  <= w_half;
                        r_cnt   <= '0;
                        r_buz   <= 1'b1;
                        r_play  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign bus.buzzer     = r_buz;
    assign bus.playing    = r_play;
    assign bus.cur_note   = r_note;
    assign bus.cur_octave = r_oct;
endmodule
